bsg_age_stamp: RTL and testbench

//  Timestamp issuer feeding an age arbiter (bsg_age_arb). Tags each newly arriving

---
 rtl/bsg_age_pkg.sv | 17 +
 rtl/bsg_age_stamp_rank.sv | 41 ++++
 rtl/bsg_age_stamp.sv | 132 +++++++++++++
 tb/tb_bsg_age_stamp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_age_pkg.sv
// Shared definitions for the age-stamp issuer and the age arbiter it feeds.
package bsg_age_pkg;

  // Issuer sequencing: normal stamping, or a one-cycle compression of live stamps
  typedef enum logic [0:0] {
    eRun    = 1'b0,
    eRebase = 1'b1
  } age_state_e;

  // A stamp width is usable when, after a rebase (counter <= inputs), at least one
  // more stamp value below the all-ones ceiling is still free.
  function automatic bit ts_width_ok(input int inputs, input int width);
    return (inputs >= 1) && (inputs <= 5) && (width > 0) && (width < 31)
           && ((1 << width) >= inputs + 2);
  endfunction

endpackage

// File: rtl/bsg_age_stamp_rank.sv
// Combinational rank of each live stamp: how many live stamps are strictly older.
module bsg_age_stamp_rank
  import bsg_age_pkg::*;
#(
  parameter int inputs_p   = 3,
  parameter int ts_width_p = 3
) (
  input  logic [inputs_p-1:0]                 live_i,
  input  logic [inputs_p-1:0][ts_width_p-1:0] ts_i,
  output logic [inputs_p-1:0][ts_width_p-1:0] rank_o,
  output logic [ts_width_p-1:0]               live_count_o
);

  // older[i][j] is set when live input j holds a strictly smaller stamp than input i
  logic [inputs_p-1:0][inputs_p-1:0] older;

  for (genvar gi = 0; gi < inputs_p; gi++) begin : g_row
    for (genvar gj = 0; gj < inputs_p; gj++) begin : g_col
      assign older[gi][gj] = live_i[gj] & (ts_i[gj] < ts_i[gi]);
    end
  end

  // Popcount of each row gives the rank; equal stamps share a rank
  always_comb begin
    for (int i = 0; i < inputs_p; i++) begin
      rank_o[i] = '0;
      for (int j = 0; j < inputs_p; j++) begin
        rank_o[i] = rank_o[i] + ts_width_p'(older[i][j]);
      end
    end
  end

  // Number of live inputs; becomes the restart value of the stamp counter
  always_comb begin
    live_count_o = '0;
    for (int i = 0; i < inputs_p; i++) begin
      live_count_o = live_count_o + ts_width_p'(live_i[i]);
    end
  end

endmodule

// File: rtl/bsg_age_stamp.sv
// Timestamp issuer for an age arbiter: stamps arriving requests with a monotonic
// counter and compresses live stamps into ranks before the counter can wrap.
module bsg_age_stamp
  import bsg_age_pkg::*;
#(
  parameter int inputs_p   = 3,
  parameter int ts_width_p = 3
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [inputs_p-1:0]                 reqs_i,
  input  logic [inputs_p-1:0]                 grants_i,
  output logic [inputs_p-1:0]                 reqs_o,
  output logic [inputs_p-1:0][ts_width_p-1:0] ts_o,
  output logic                                arb_ready_o
);

  if (!ts_width_ok(inputs_p, ts_width_p)) begin : g_bad_width
    $error("bsg_age_stamp: ts_width_p too narrow for inputs_p (need 2**w >= inputs_p+2)");
  end

  localparam logic [ts_width_p-1:0] max_lp = '1;

  logic [inputs_p-1:0]                 live_q, live_d;
  logic [inputs_p-1:0][ts_width_p-1:0] stamp_q, stamp_d;
  logic [ts_width_p-1:0]               counter_q, counter_d;
  age_state_e                          state_q;
  logic                                ready_q;

  logic [inputs_p-1:0]                 pending;
  logic [inputs_p-1:0]                 accept;
  logic [inputs_p-1:0]                 grant_clr;
  logic [inputs_p-1:0]                 withdraw;
  logic [inputs_p-1:0][ts_width_p-1:0] rank;
  logic [ts_width_p-1:0]               live_count;
  logic                                any_pending;
  logic                                at_max;

  for (genvar gi = 0; gi < inputs_p; gi++) begin : g_in
    assign pending[gi]   = reqs_i[gi] & ~live_q[gi];
    assign withdraw[gi]  = live_q[gi] & ~reqs_i[gi];
    assign reqs_o[gi]    = live_q[gi] & reqs_i[gi] & ready_q;
    // Only a grant on a request we are actually presenting retires it
    assign grant_clr[gi] = grants_i[gi] & reqs_o[gi];
    // Arrivals are stamped only while running and while a stamp value is free;
    // at the ceiling they wait for the rebase and retry
    assign accept[gi]    = pending[gi] & (state_q == eRun) & ~at_max;
  end

  assign any_pending = |pending;
  assign at_max      = (counter_q == max_lp);
  assign ts_o        = stamp_q;
  assign arb_ready_o = ready_q;

  bsg_age_stamp_rank #(
    .inputs_p  (inputs_p),
    .ts_width_p(ts_width_p)
  ) u_rank (
    .live_i      (live_q),
    .ts_i        (stamp_q),
    .rank_o      (rank),
    .live_count_o(live_count)
  );

  // Next live/stamp/counter: stamp arrivals while running, compress to ranks on rebase
  always_comb begin
    live_d    = live_q;
    stamp_d   = stamp_q;
    counter_d = counter_q;
    if (state_q == eRun) begin
      live_d = (live_q & ~withdraw & ~grant_clr) | accept;
      for (int i = 0; i < inputs_p; i++) begin
        if (accept[i]) stamp_d[i] = counter_q;
      end
      if (|accept) counter_d = counter_q + ts_width_p'(1);
    end else begin
      // Ranks use the pre-withdraw live set; a withdrawn input just leaves a gap
      live_d = live_q & ~withdraw;
      for (int i = 0; i < inputs_p; i++) begin
        stamp_d[i] = live_q[i] ? rank[i] : '0;
      end
      counter_d = live_count;
    end
  end

  // Data registers: live bits, per-input stamps and the stamp counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      live_q    <= '0;
      stamp_q   <= '0;
      counter_q <= '0;
    end else begin
      live_q    <= live_d;
      stamp_q   <= stamp_d;
      counter_q <= counter_d;
    end
  end

  // Run/rebase sequencing; the arbiter enable is registered alongside the state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eRun;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        eRun: begin
          if (at_max && any_pending) begin
            state_q <= eRebase;
            ready_q <= 1'b0;
          end
        end
        eRebase: begin
          state_q <= eRun;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= eRun;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The arbiter must never grant more than one input per cycle
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(grants_i))
      else $error("bsg_age_stamp: grants_i is not onehot0");
    end
  end

endmodule

// File: tb/tb_bsg_age_stamp.sv
// Bench for bsg_age_stamp: directed scenarios plus random traffic checked against
// an accept-time model, with the bench acting as the age arbiter.
module tb_bsg_age_stamp;

  localparam int N     = 3;
  localparam int W     = 3;
  localparam int MAXV  = (1 << W) - 1;
  localparam int LIMIT = N * (1 << W);

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [N-1:0]        reqs_i;
  logic [N-1:0]        grants_i;
  logic [N-1:0]        reqs_o;
  logic [N-1:0][W-1:0] ts_o;
  logic                arb_ready_o;

  int checks = 0;
  int errors = 0;

  // Reference model: per-input accept cycle, stamp value, counter, rebase flag
  bit m_live[N];
  int m_acc[N];
  int m_stamp[N];
  int m_cnt;
  bit m_rebase;
  int cyc = 0;

  always #5 clk_i = ~clk_i;

  bsg_age_stamp #(
    .inputs_p  (N),
    .ts_width_p(W)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (reqs_i),
    .grants_i   (grants_i),
    .reqs_o     (reqs_o),
    .ts_o       (ts_o),
    .arb_ready_o(arb_ready_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_live[i]  = 1'b0;
      m_acc[i]   = 0;
      m_stamp[i] = 0;
    end
    m_cnt    = 0;
    m_rebase = 1'b0;
  endtask

  function automatic logic [N-1:0] exp_reqs(input logic [N-1:0] req);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_live[i] && req[i] && !m_rebase;
    return r;
  endfunction

  function automatic logic [N*W-1:0] exp_ts();
    logic [N*W-1:0] t;
    for (int i = 0; i < N; i++) t[i*W +: W] = W'(m_stamp[i]);
    return t;
  endfunction

  // Apply one clock edge to the model, given the inputs presented in that cycle
  task automatic model_edge(input logic [N-1:0] req, input logic [N-1:0] g);
    bit           old_live[N];
    logic [N-1:0] ro;
    logic [N-1:0] pend;
    int           r;
    int           n;
    old_live = m_live;
    ro       = exp_reqs(req);
    if (!m_rebase) begin
      for (int i = 0; i < N; i++) pend[i] = req[i] && !old_live[i];
      if (pend != '0 && m_cnt == MAXV) begin
        m_rebase = 1'b1;
      end else if (pend != '0) begin
        for (int i = 0; i < N; i++) begin
          if (pend[i]) begin
            m_live[i]  = 1'b1;
            m_stamp[i] = m_cnt;
            m_acc[i]   = cyc;
          end
        end
        m_cnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (old_live[i] && (!req[i] || (g[i] && ro[i]))) m_live[i] = 1'b0;
      end
    end else begin
      n = 0;
      for (int i = 0; i < N; i++) begin
        if (old_live[i]) begin
          r = 0;
          for (int j = 0; j < N; j++) if (old_live[j] && m_acc[j] < m_acc[i]) r++;
          m_stamp[i] = r;
          n++;
        end else begin
          m_stamp[i] = 0;
        end
      end
      m_cnt = n;
      for (int i = 0; i < N; i++) if (old_live[i] && !req[i]) m_live[i] = 1'b0;
      m_rebase = 1'b0;
    end
    cyc++;
  endtask

  // One cycle, entered just after a falling edge: drive, check, grant, clock
  task automatic step(input logic [N-1:0] req, input bit auto_g, input logic [N-1:0] gmask);
    logic [N-1:0] ro;
    logic [N-1:0] g;
    int           best;
    int           oldest;
    reqs_i   = req;
    grants_i = '0;
    #1;
    ro = exp_reqs(req);
    check_eq("arb_ready_o", arb_ready_o, !m_rebase);
    check_eq("reqs_o", reqs_o, ro);
    check_eq("ts_o", ts_o, exp_ts());
    for (int i = 0; i < N; i++) begin
      if (m_live[i]) check_eq("wait_bound", (cyc - m_acc[i]) <= LIMIT, 1);
    end
    g = '0;
    if (auto_g) begin
      best = -1;
      for (int i = 0; i < N; i++) begin
        if (reqs_o[i] === 1'b1 && (best < 0 || ts_o[i] < ts_o[best])) best = i;
      end
      if (best >= 0) g[best] = 1'b1;
    end else begin
      g = gmask;
    end
    grants_i = g;
    for (int i = 0; i < N; i++) begin
      if (g[i] && ro[i] && auto_g) begin
        oldest = 32'h7fffffff;
        for (int j = 0; j < N; j++) if (ro[j] && m_acc[j] < oldest) oldest = m_acc[j];
        check_eq("grant_oldest", m_acc[i], oldest);
      end
    end
    @(posedge clk_i);
    model_edge(req, g);
    @(negedge clk_i);
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives
  task automatic mid_reset();
    #2 reset_i = 1'b1;
    #1;
    check_eq("async_reset_reqs_o", reqs_o, 0);
    check_eq("async_reset_ts_o", ts_o, 0);
    check_eq("async_reset_ready", arb_ready_o, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
  endtask

  initial begin : main
    logic [N-1:0] req;
    logic [N-1:0] gm;
    logic [N-1:0] ro;
    int           k;

    reset_i  = 1'b1;
    reqs_i   = '0;
    grants_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check_eq("reset_reqs_o", reqs_o, 0);
    check_eq("reset_ts_o", ts_o, 0);
    check_eq("reset_ready", arb_ready_o, 1);
    @(negedge clk_i);

    // Simultaneous arrival shares stamp 0; the next arrival gets stamp 1
    step(3'b101, 1'b0, 3'b000);
    step(3'b111, 1'b0, 3'b000);
    check_eq("tie_then_next_ts1", ts_o[1], 1);
    step(3'b000, 1'b0, 3'b000);
    mid_reset();

    // Hold input 0, churn input 1 to the ceiling, then arrive on input 2
    step(3'b001, 1'b0, 3'b000);
    step(3'b011, 1'b0, 3'b000);
    for (int c = 0; c < 5; c++) begin
      step(3'b011, 1'b0, 3'b010);
      step(3'b011, 1'b0, 3'b000);
    end
    step(3'b111, 1'b0, 3'b000);
    check_eq("rebase_ready_low", arb_ready_o, 0);
    check_eq("rebase_reqs_o", reqs_o, 0);
    step(3'b111, 1'b0, 3'b000);
    step(3'b111, 1'b0, 3'b000);
    check_eq("after_rebase_ts", ts_o, 9'h088);

    // Withdraw input 1 while live, then re-raise it for a fresh, younger stamp
    reqs_i = 3'b101;
    #1;
    check_eq("withdraw_same_cycle", reqs_o[1], 0);
    @(negedge clk_i);
    step(3'b101, 1'b0, 3'b000);
    step(3'b111, 1'b0, 3'b000);
    check_eq("reraise_younger", ts_o[1] > ts_o[2], 1);
    step(3'b000, 1'b0, 3'b000);

    // Random traffic, with the bench granting the oldest stamp like the arbiter
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
      if (c == 1500) begin
        reqs_i = req;
        mid_reset();
      end
      if ($urandom_range(0, 7) == 0) begin
        k  = $urandom_range(0, N - 1);
        gm = '0;
        ro = exp_reqs(req);
        if (!ro[k]) gm[k] = 1'b1;
        step(req, 1'b0, gm);
      end else begin
        step(req, 1'b1, 3'b000);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
